// File: rtl/regfile_mp.sv
// Multi-port register file: RD_PORTS registered read ports, two prioritised write ports
// (B wins), optional hardwired-zero r0 and a sequential clear engine. Optional macro: REGFILE_BYPASS_EN.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | normal operation, writes accepted, clrReq sampled
// ST_SWEEP | zeroing one register per cycle, writes dropped
// ST_DONE  | one-cycle clrDone pulse, writes still dropped
module regfile_mp #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_SIZE = 3,
    parameter int REG_MAX   = 2**ADDR_SIZE,
    parameter int RD_PORTS  = 2,
    parameter int ZERO_REG  = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [RD_PORTS-1:0]             rdEn,
    input  logic [RD_PORTS*ADDR_SIZE-1:0]   rdAddr,
    output logic [RD_PORTS*WORD_SIZE-1:0]   rdData,
    output logic [RD_PORTS-1:0]             rdValid,
    input  logic                            wrtEnA,
    input  logic [ADDR_SIZE-1:0]            wrtAddrA,
    input  logic [WORD_SIZE-1:0]            wrtDataA,
    input  logic                            wrtEnB,
    input  logic [ADDR_SIZE-1:0]            wrtAddrB,
    input  logic [WORD_SIZE-1:0]            wrtDataB,
    input  logic                            clrReq,
    output logic                            clrBusy,
    output logic                            clrDone
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [ADDR_SIZE-1:0] LAST_IDX = ADDR_SIZE'(REG_MAX - 1);

    state_t                                 state_q, state_d;
    logic [ADDR_SIZE-1:0]                   cnt_q, cnt_d;
    logic [WORD_SIZE-1:0]                   gen_reg_q [REG_MAX];
    logic [WORD_SIZE-1:0]                   gen_reg_d [REG_MAX];
    logic [RD_PORTS-1:0][WORD_SIZE-1:0]     rd_data_q, rd_data_d;
    logic [RD_PORTS-1:0]                    rd_valid_q, rd_valid_d;

    logic                                   wr_a_ok;
    logic                                   wr_b_ok;

    // Out-of-range addresses (REG_MAX < 2**ADDR_SIZE) and a hardwired r0 never take writes.
    function automatic logic addr_ok(input logic [ADDR_SIZE-1:0] a);
        return (int'(a) < REG_MAX) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clrBusy = 1'b0;
        clrDone = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clrReq) begin
                    state_d = ST_SWEEP;
                    cnt_d   = '0;
                end
            end
            ST_SWEEP: begin
                clrBusy = 1'b1;
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                clrDone = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        wr_a_ok = wrtEnA && (state_q == ST_IDLE) && addr_ok(wrtAddrA);
        wr_b_ok = wrtEnB && (state_q == ST_IDLE) && addr_ok(wrtAddrB);
    end

    always_comb begin
        for (int i = 0; i < REG_MAX; i++) begin
            gen_reg_d[i] = gen_reg_q[i];
            if (wr_a_ok && (wrtAddrA == ADDR_SIZE'(i))) begin
                gen_reg_d[i] = wrtDataA;
            end
            if (wr_b_ok && (wrtAddrB == ADDR_SIZE'(i))) begin
                gen_reg_d[i] = wrtDataB;
            end
            if ((state_q == ST_SWEEP) && (cnt_q == ADDR_SIZE'(i))) begin
                gen_reg_d[i] = '0;
            end
        end
    end

    // Reads see the array before this edge's writes and sweep zeroing; only the
    // write ports may be forwarded, never the clear engine.
    always_comb begin
        logic [ADDR_SIZE-1:0] ra;
        logic [WORD_SIZE-1:0] rv;
        ra         = '0;
        rv         = '0;
        rd_data_d  = rd_data_q;
        rd_valid_d = rdEn;
        for (int p = 0; p < RD_PORTS; p++) begin
            ra = rdAddr[p*ADDR_SIZE +: ADDR_SIZE];
            rv = '0;
            if (int'(ra) < REG_MAX) begin
                rv = gen_reg_q[ra];
            end
`ifdef REGFILE_BYPASS_EN
            if (wr_b_ok && (wrtAddrB == ra)) begin
                rv = wrtDataB;
            end else if (wr_a_ok && (wrtAddrA == ra)) begin
                rv = wrtDataA;
            end
`endif
            if ((ZERO_REG != 0) && (ra == '0)) begin
                rv = '0;
            end
            if (rdEn[p]) begin
                rd_data_d[p] = rv;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            gen_reg_q  <= '{default: '0};
            rd_data_q  <= '0;
            rd_valid_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gen_reg_q  <= gen_reg_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rdData  = rd_data_q;
    assign rdValid = rd_valid_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed steps plus random traffic against an
// array-based reference model; a second instance runs with ZERO_REG=1.
module tb_regfile_mp;

    localparam int W = 16;
    localparam int A = 3;
    localparam int N = 8;
    localparam int P = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [P-1:0]   rd_en;
    logic [P*A-1:0] rd_addr;
    logic           wr_en_a, wr_en_b;
    logic [A-1:0]   wr_addr_a, wr_addr_b;
    logic [W-1:0]   wr_data_a, wr_data_b;
    logic           clr_req;

    logic [P*W-1:0] rd_data   [2];
    logic [P-1:0]   rd_valid  [2];
    logic           clr_busy  [2];
    logic           clr_done  [2];

    always #5 clk = ~clk;

    regfile_mp #(.WORD_SIZE(W), .ADDR_SIZE(A), .REG_MAX(N), .RD_PORTS(P), .ZERO_REG(0)) u_dut (
        .clk(clk), .rst(rst), .rdEn(rd_en), .rdAddr(rd_addr),
        .rdData(rd_data[0]), .rdValid(rd_valid[0]),
        .wrtEnA(wr_en_a), .wrtAddrA(wr_addr_a), .wrtDataA(wr_data_a),
        .wrtEnB(wr_en_b), .wrtAddrB(wr_addr_b), .wrtDataB(wr_data_b),
        .clrReq(clr_req), .clrBusy(clr_busy[0]), .clrDone(clr_done[0])
    );

    regfile_mp #(.WORD_SIZE(W), .ADDR_SIZE(A), .REG_MAX(N), .RD_PORTS(P), .ZERO_REG(1)) u_dut_z (
        .clk(clk), .rst(rst), .rdEn(rd_en), .rdAddr(rd_addr),
        .rdData(rd_data[1]), .rdValid(rd_valid[1]),
        .wrtEnA(wr_en_a), .wrtAddrA(wr_addr_a), .wrtDataA(wr_data_a),
        .wrtEnB(wr_en_b), .wrtAddrB(wr_addr_b), .wrtDataB(wr_data_b),
        .clrReq(clr_req), .clrBusy(clr_busy[1]), .clrDone(clr_done[1])
    );

    // Reference model: inst 1 is the ZERO_REG=1 instance. phase 0 idle, 1 sweeping, 2 done.
    logic [W-1:0] mdl    [2][N];
    logic [W-1:0] exp_rd [2][P];
    logic [P-1:0] exp_vld;
    int           phase;
    int           sweep_idx;
    int           vectors;
    int           miscompares;
    int           busy_cnt;
    int           done_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < N; r++) mdl[k][r] = '0;
            for (int p = 0; p < P; p++) exp_rd[k][p] = '0;
        end
        exp_vld   = '0;
        phase     = 0;
        sweep_idx = 0;
    endtask

    task automatic model_step();
        bit           wr_ok;
        logic [A-1:0] a;
        logic [W-1:0] v;
        wr_ok = (phase == 0);
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < P; p++) begin
                if (rd_en[p]) begin
                    a = rd_addr[p*A +: A];
                    v = mdl[k][a];
`ifdef REGFILE_BYPASS_EN
                    if (wr_ok && wr_en_b && wr_addr_b == a) v = wr_data_b;
                    else if (wr_ok && wr_en_a && wr_addr_a == a) v = wr_data_a;
`endif
                    if (k == 1 && a == 0) v = '0;
                    exp_rd[k][p] = v;
                end
            end
        end
        exp_vld = rd_en;
        if (wr_ok) begin
            for (int k = 0; k < 2; k++) begin
                if (wr_en_a && !(k == 1 && wr_addr_a == 0)) mdl[k][wr_addr_a] = wr_data_a;
                if (wr_en_b && !(k == 1 && wr_addr_b == 0)) mdl[k][wr_addr_b] = wr_data_b;
            end
        end
        case (phase)
            0: if (clr_req) begin phase = 1; sweep_idx = 0; end
            1: begin
                for (int k = 0; k < 2; k++) mdl[k][sweep_idx] = '0;
                sweep_idx++;
                if (sweep_idx == N) phase = 2;
            end
            default: phase = 0;
        endcase
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rd_data[%0d]", k), 32'(rd_data[k]), {exp_rd[k][1], exp_rd[k][0]});
            check($sformatf("rd_valid[%0d]", k), 32'(rd_valid[k]), 32'(exp_vld));
            check($sformatf("clr_busy[%0d]", k), 32'(clr_busy[k]), 32'(phase == 1));
            check($sformatf("clr_done[%0d]", k), 32'(clr_done[k]), 32'(phase == 2));
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
        busy_cnt += int'(clr_busy[0]);
        done_cnt += int'(clr_done[0]);
    endtask

    task automatic idle_inputs();
        rd_en = '0; rd_addr = '0;
        wr_en_a = 0; wr_addr_a = '0; wr_data_a = '0;
        wr_en_b = 0; wr_addr_b = '0; wr_data_b = '0;
        clr_req = 0;
    endtask

    task automatic mid_reset();
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        check("reset_immediate_data", 32'(rd_data[0]), 32'h0);
        rst = 1'b0;
    endtask

    task automatic read_all();
        for (int a = 0; a < N; a++) begin
            idle_inputs();
            rd_en = 2'b11;
            rd_addr = {3'(N - 1 - a), 3'(a)};
            cycle();
        end
        idle_inputs();
    endtask

    task automatic load_random();
        for (int a = 0; a < N; a++) begin
            idle_inputs();
            wr_en_a = 1; wr_addr_a = 3'(a); wr_data_a = 16'($urandom_range(1, 16'hFFFF));
            cycle();
        end
        idle_inputs();
    endtask

    task automatic random_traffic();
        rd_en     = 2'($urandom);
        rd_addr   = 6'($urandom);
        wr_en_a   = 1'($urandom);
        wr_addr_a = 3'($urandom);
        wr_data_a = 16'($urandom);
        wr_en_b   = 1'($urandom);
        wr_addr_b = 3'($urandom);
        wr_data_b = 16'($urandom);
    endtask

    initial begin
        vectors = 0; miscompares = 0; busy_cnt = 0; done_cnt = 0;
        idle_inputs();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;

        // all ones, then async reset mid-cycle
        for (int a = 0; a < N; a++) begin
            idle_inputs();
            wr_en_a = 1; wr_addr_a = 3'(a); wr_data_a = 16'hFFFF;
            cycle();
        end
        idle_inputs();
        rd_en = 2'b01; rd_addr = 6'd7;
        cycle();
        check("preload_ffff", 32'(rd_data[0][15:0]), 32'hFFFF);
        mid_reset();
        read_all();

        // dual write conflict, then disjoint addresses
        wr_en_a = 1; wr_addr_a = 3'd3; wr_data_a = 16'h1111;
        wr_en_b = 1; wr_addr_b = 3'd3; wr_data_b = 16'h2222;
        cycle();
        idle_inputs();
        rd_en = 2'b01; rd_addr = 6'd3;
        cycle();
        check("conflict_b_wins", 32'(rd_data[0][15:0]), 32'h2222);
        idle_inputs();
        wr_en_a = 1; wr_addr_a = 3'd2; wr_data_a = 16'h5A5A;
        wr_en_b = 1; wr_addr_b = 3'd5; wr_data_b = 16'hA5A5;
        cycle();
        idle_inputs();
        rd_en = 2'b11; rd_addr = {3'd5, 3'd2};
        cycle();
        check("disjoint_writes", 32'(rd_data[0]), 32'hA5A5_5A5A);

        // both read ports, then hold
        idle_inputs();
        wr_en_a = 1; wr_addr_a = 3'd4; wr_data_a = 16'hBEEF;
        wr_en_b = 1; wr_addr_b = 3'd6; wr_data_b = 16'hCAFE;
        cycle();
        idle_inputs();
        rd_en = 2'b11; rd_addr = {3'd6, 3'd4};
        cycle();
        check("dual_read_data", 32'(rd_data[0]), 32'hCAFE_BEEF);
        check("dual_read_valid", 32'(rd_valid[0]), 32'h3);
        idle_inputs();
        cycle();
        check("hold_data", 32'(rd_data[0]), 32'hCAFE_BEEF);
        check("hold_valid", 32'(rd_valid[0]), 32'h0);

        // same-edge read of a register being written
        idle_inputs();
        wr_en_a = 1; wr_addr_a = 3'd1; wr_data_a = 16'h1234;
        rd_en = 2'b01; rd_addr = 6'd1;
        cycle();
`ifdef REGFILE_BYPASS_EN
        check("same_edge_read", 32'(rd_data[0][15:0]), 32'h1234);
`else
        check("same_edge_read", 32'(rd_data[0][15:0]), 32'h0000);
`endif
        idle_inputs();
        rd_en = 2'b01; rd_addr = 6'd1;
        cycle();
        check("write_then_read", 32'(rd_data[0][15:0]), 32'h1234);

        // hardwired zero register on the second instance
        idle_inputs();
        wr_en_a = 1; wr_addr_a = 3'd0; wr_data_a = 16'hAAAA;
        wr_en_b = 1; wr_addr_b = 3'd1; wr_data_b = 16'h5555;
        cycle();
        idle_inputs();
        rd_en = 2'b11; rd_addr = {3'd1, 3'd0};
        cycle();
        check("zero_reg_read", 32'(rd_data[1]), 32'h5555_0000);
        check("plain_reg0_read", 32'(rd_data[0]), 32'h5555_AAAA);

        // full clear sweep with writes attempted while busy
        load_random();
        busy_cnt = 0; done_cnt = 0;
        clr_req = 1;
        cycle();
        for (int c = 0; c < 9; c++) begin
            idle_inputs();
            random_traffic();
            cycle();
        end
        check("sweep_busy_cycles", 32'(busy_cnt), 32'd8);
        check("sweep_done_pulses", 32'(done_cnt), 32'd1);
        idle_inputs();
        read_all();

        // reset three cycles into a sweep
        load_random();
        done_cnt = 0;
        clr_req = 1;
        cycle();
        idle_inputs();
        repeat (2) cycle();
        mid_reset();
        repeat (4) cycle();
        check("abort_no_done", 32'(done_cnt), 32'd0);
        read_all();

        // clrReq held high: back-to-back sweeps
        load_random();
        clr_req = 1;
        for (int c = 0; c < 22; c++) begin
            random_traffic();
            cycle();
        end
        idle_inputs();
        for (int c = 0; c < 12 && phase != 0; c++) cycle();
        check("held_req_settles_idle", 32'(phase), 32'd0);

        // random traffic with occasional clears
        for (int c = 0; c < 400; c++) begin
            random_traffic();
            clr_req = ($urandom_range(0, 39) == 0);
            cycle();
        end
        idle_inputs();
        for (int c = 0; c < 12 && phase != 0; c++) cycle();
        read_all();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
